pio_shift_engine: RTL and testbench

Parametrised ISR/OSR shift engine for the PIO state machine, generalising the fixed 32-bit shift registers to `W` bits. It adds blocking and non-blocking FIFO handshakes, IfFull/IfEmpty conditions, and autopush/autopull with explicit stall states. It sits between the instruction decoder (commands) and the TX/RX FIFOs. It owns all shift-register state and raises `stall` to hold the PC.

---
 rtl/pio_shift_engine.sv | 225 ++++++++++++++++++++++
 tb/tb_pio_shift_engine.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pio_shift_engine.sv
// W-bit ISR/OSR shift engine for the PIO state machine: IN/OUT shifting,
// PUSH/PULL FIFO handshakes, autopush/autopull and PC stall generation.
module pio_shift_engine #(
  parameter int W  = 32,
  parameter int CW = $clog2(W)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          restart,
  input  logic          en,
  input  logic [2:0]    cmd,
  input  logic [CW-1:0] cmd_n,
  input  logic          cmd_block,
  input  logic          cmd_cond,
  input  logic [W-1:0]  cmd_data,
  input  logic [W-1:0]  x_in,
  input  logic          shift_right_in,
  input  logic          shift_right_out,
  input  logic          auto_push,
  input  logic          auto_pull,
  input  logic [CW-1:0] push_thresh,
  input  logic [CW-1:0] pull_thresh,
  output logic [W-1:0]  rx_data,
  output logic          rx_valid,
  input  logic          rx_ready,
  input  logic [W-1:0]  tx_data,
  input  logic          tx_valid,
  output logic          tx_ready,
  output logic [W-1:0]  out_bits,
  output logic          out_valid,
  output logic [W-1:0]  isr,
  output logic [W-1:0]  osr,
  output logic [CW:0]   isr_count,
  output logic [CW:0]   osr_count,
  output logic          stall
);
  localparam logic [1:0] ST_IDLE          = 2'd0;
  localparam logic [1:0] ST_PUSH_WAIT     = 2'd1;
  localparam logic [1:0] ST_PULL_WAIT     = 2'd2;
  localparam logic [1:0] ST_PULL_THEN_OUT = 2'd3;

  localparam logic [2:0] CMD_IN      = 3'd1;
  localparam logic [2:0] CMD_OUT     = 3'd2;
  localparam logic [2:0] CMD_PUSH    = 3'd3;
  localparam logic [2:0] CMD_PULL    = 3'd4;
  localparam logic [2:0] CMD_SET_ISR = 3'd5;
  localparam logic [2:0] CMD_SET_OSR = 3'd6;

  localparam int          CNTW = CW + 1;
  localparam logic [CW:0] FULL = CNTW'(W);

  function automatic logic [CW:0] expand(input logic [CW-1:0] v);
    return (v == '0) ? FULL : {1'b0, v};
  endfunction

  function automatic logic [CW:0] sat_add(input logic [CW:0] a, input logic [CW:0] b);
    logic [CW+1:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return (sum > {1'b0, FULL}) ? FULL : sum[CW:0];
  endfunction

  // Double-width concatenation shift handles every n in 1..W, including full replacement.
  function automatic logic [W-1:0] shift_in(input logic [W-1:0] cur, input logic [W-1:0] data,
                                            input logic [CW:0] n, input logic right);
    logic [2*W-1:0] cat;
    logic [W-1:0]   res;
    if (right) begin
      cat = {data, cur} >> n;
      res = cat[W-1:0];
    end else begin
      cat = {cur, data << (FULL - n)} << n;
      res = cat[2*W-1:W];
    end
    return res;
  endfunction

  logic [1:0]   state_q, state_d;
  logic [W-1:0] isr_q, isr_d, osr_q, osr_d, out_bits_q, out_bits_d;
  logic [CW:0]  isr_count_q, isr_count_d, osr_count_q, osr_count_d, pend_n_q, pend_n_d;
  logic         out_valid_q, out_valid_d;

  logic         pulling, push_skip, pull_skip, nb_pull_ready;
  logic [CW:0]  n_eff, push_lvl, pull_lvl, out_n, out_cnt_src;
  logic [W-1:0] out_src, out_res, out_rem;

  assign n_eff    = expand(cmd_n);
  assign push_lvl = expand(push_thresh);
  assign pull_lvl = expand(pull_thresh);

  assign push_skip = cmd_cond && (isr_count_q < push_lvl);
  assign pull_skip = cmd_cond && (osr_count_q < pull_lvl);

  // The deferred OUT of an autopull operates on the word arriving from TX with an empty count.
  assign pulling     = (state_q == ST_PULL_THEN_OUT);
  assign out_src     = pulling ? tx_data : osr_q;
  assign out_cnt_src = pulling ? '0 : osr_count_q;
  assign out_n       = pulling ? pend_n_q : n_eff;
  assign out_res     = shift_right_out ? (out_src & ~({W{1'b1}} << out_n))
                                       : (out_src >> (FULL - out_n));
  assign out_rem     = shift_right_out ? (out_src >> out_n) : (out_src << out_n);

  assign nb_pull_ready = (state_q == ST_IDLE) && en && (cmd == CMD_PULL) &&
                         !pull_skip && !cmd_block && tx_valid;

  always_comb begin
    state_d     = state_q;
    isr_d       = isr_q;
    isr_count_d = isr_count_q;
    osr_d       = osr_q;
    osr_count_d = osr_count_q;
    pend_n_d    = pend_n_q;
    out_bits_d  = out_bits_q;
    out_valid_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (en) begin
          case (cmd)
            CMD_IN: begin
              isr_d       = shift_in(isr_q, cmd_data, n_eff, shift_right_in);
              isr_count_d = sat_add(isr_count_q, n_eff);
              if (auto_push && (isr_count_d >= push_lvl)) state_d = ST_PUSH_WAIT;
            end
            CMD_OUT: begin
              if (auto_pull && (osr_count_q >= pull_lvl)) begin
                state_d  = ST_PULL_THEN_OUT;
                pend_n_d = n_eff;
              end else begin
                out_bits_d  = out_res;
                osr_d       = out_rem;
                osr_count_d = sat_add(out_cnt_src, out_n);
                out_valid_d = 1'b1;
              end
            end
            CMD_PUSH: begin
              if (!push_skip) begin
                if (cmd_block || rx_ready) begin
                  state_d = ST_PUSH_WAIT;
                end else begin
                  isr_d       = '0;
                  isr_count_d = '0;
                end
              end
            end
            CMD_PULL: begin
              if (!pull_skip) begin
                if (cmd_block) begin
                  state_d = ST_PULL_WAIT;
                end else begin
                  osr_d       = tx_valid ? tx_data : x_in;
                  osr_count_d = '0;
                end
              end
            end
            CMD_SET_ISR: begin
              isr_d       = cmd_data;
              isr_count_d = '0;
            end
            CMD_SET_OSR: begin
              osr_d       = cmd_data;
              osr_count_d = '0;
            end
            default: ;
          endcase
        end
      end
      ST_PUSH_WAIT: begin
        if (rx_ready) begin
          isr_d       = '0;
          isr_count_d = '0;
          state_d     = ST_IDLE;
        end
      end
      ST_PULL_WAIT: begin
        if (tx_valid) begin
          osr_d       = tx_data;
          osr_count_d = '0;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        if (tx_valid) begin
          out_bits_d  = out_res;
          osr_d       = out_rem;
          osr_count_d = sat_add(out_cnt_src, out_n);
          out_valid_d = 1'b1;
          state_d     = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset || restart) begin
      state_q     <= ST_IDLE;
      isr_q       <= '0;
      isr_count_q <= '0;
      osr_q       <= '0;
      osr_count_q <= FULL;
      pend_n_q    <= '0;
      out_bits_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      isr_q       <= isr_d;
      isr_count_q <= isr_count_d;
      osr_q       <= osr_d;
      osr_count_q <= osr_count_d;
      pend_n_q    <= pend_n_d;
      out_bits_q  <= out_bits_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Handshakes are masked during a clear so an abandoned wait never transfers.
  assign rx_valid  = (state_q == ST_PUSH_WAIT) && !(reset || restart);
  assign tx_ready  = ((state_q == ST_PULL_WAIT) || pulling || nb_pull_ready) && !(reset || restart);
  assign rx_data   = isr_q;
  assign stall     = (state_q != ST_IDLE);
  assign isr       = isr_q;
  assign osr       = osr_q;
  assign isr_count = isr_count_q;
  assign osr_count = osr_count_q;
  assign out_bits  = out_bits_q;
  assign out_valid = out_valid_q;
endmodule

// File: tb/tb_pio_shift_engine.sv
// Self-checking bench for pio_shift_engine (W=32): vector table for IN/OUT/SET
// plus hand sequences for autopush, autopull, PULL/PUSH variants and clears.
module tb_pio_shift_engine;
  localparam int W = 32;
  localparam int CW = 5;

  localparam logic [2:0] CMD_NOP = 3'd0, CMD_IN = 3'd1, CMD_OUT = 3'd2, CMD_PUSH = 3'd3;
  localparam logic [2:0] CMD_PULL = 3'd4, CMD_SET_ISR = 3'd5, CMD_SET_OSR = 3'd6, CMD_RSVD = 3'd7;

  logic clk = 1'b0;
  logic reset, restart, en;
  logic [2:0] cmd;
  logic [CW-1:0] cmd_n;
  logic cmd_block, cmd_cond;
  logic [W-1:0] cmd_data, x_in;
  logic shift_right_in, shift_right_out, auto_push, auto_pull;
  logic [CW-1:0] push_thresh, pull_thresh;
  logic [W-1:0] rx_data;
  logic rx_valid, rx_ready;
  logic [W-1:0] tx_data;
  logic tx_valid, tx_ready;
  logic [W-1:0] out_bits;
  logic out_valid;
  logic [W-1:0] isr, osr;
  logic [CW:0] isr_count, osr_count;
  logic stall;

  pio_shift_engine #(.W(W), .CW(CW)) dut (
    .clk(clk), .reset(reset), .restart(restart), .en(en),
    .cmd(cmd), .cmd_n(cmd_n), .cmd_block(cmd_block), .cmd_cond(cmd_cond),
    .cmd_data(cmd_data), .x_in(x_in),
    .shift_right_in(shift_right_in), .shift_right_out(shift_right_out),
    .auto_push(auto_push), .auto_pull(auto_pull),
    .push_thresh(push_thresh), .pull_thresh(pull_thresh),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .out_bits(out_bits), .out_valid(out_valid),
    .isr(isr), .osr(osr), .isr_count(isr_count), .osr_count(osr_count),
    .stall(stall)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  cmd;
    logic [4:0]  n;
    logic [31:0] data;
    logic        right;
    logic        en;
    logic [31:0] exp_isr;
    logic [5:0]  exp_isr_cnt;
    logic [31:0] exp_osr;
    logic [5:0]  exp_osr_cnt;
    logic        out_exp;
    logic [31:0] exp_out;
  } vec_t;

  vec_t vecs[14];
  int compared = 0;
  int failed = 0;
  logic [31:0] rx_exp_q[$];
  logic [31:0] out_exp_q[$];

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      failed++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic [2:0] c, input logic [4:0] n, input logic [31:0] d,
                                input logic blk, input logic cnd);
    cmd = c; cmd_n = n; cmd_data = d; cmd_block = blk; cmd_cond = cnd;
    tick();
    cmd = CMD_NOP;
  endtask

  task automatic do_reset();
    reset = 1'b1; restart = 1'b0; en = 1'b1; cmd = CMD_NOP; cmd_n = '0; cmd_block = 1'b0;
    cmd_cond = 1'b0; cmd_data = '0; x_in = '0; shift_right_in = 1'b1; shift_right_out = 1'b1;
    auto_push = 1'b0; auto_pull = 1'b0; push_thresh = '0; pull_thresh = '0;
    rx_ready = 1'b0; tx_data = '0; tx_valid = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Scoreboard side: every transfer or OUT pulse must match the oldest expectation.
  always @(negedge clk) begin
    logic [31:0] e;
    if (rx_valid === 1'b1 && rx_ready === 1'b1) begin
      if (rx_exp_q.size() == 0) check_output("rx_unexpected", {32'h0, rx_data}, 64'hFFFF_FFFF_FFFF_FFFF);
      else begin
        e = rx_exp_q.pop_front();
        check_output("rx_data", {32'h0, rx_data}, {32'h0, e});
      end
    end
    if (out_valid === 1'b1) begin
      if (out_exp_q.size() == 0) check_output("out_unexpected", {32'h0, out_bits}, 64'hFFFF_FFFF_FFFF_FFFF);
      else begin
        e = out_exp_q.pop_front();
        check_output("out_bits", {32'h0, out_bits}, {32'h0, e});
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0]  = '{CMD_IN,      5'd8,  32'h000000A5, 1'b1, 1'b1, 32'hA5000000, 6'd8,  32'h0,        6'd32, 1'b0, 32'h0};
    vecs[1]  = '{CMD_IN,      5'd4,  32'h00000003, 1'b1, 1'b1, 32'h3A500000, 6'd12, 32'h0,        6'd32, 1'b0, 32'h0};
    vecs[2]  = '{CMD_IN,      5'd8,  32'h000000FF, 1'b0, 1'b1, 32'h500000FF, 6'd20, 32'h0,        6'd32, 1'b0, 32'h0};
    vecs[3]  = '{CMD_IN,      5'd0,  32'h12345678, 1'b1, 1'b1, 32'h12345678, 6'd32, 32'h0,        6'd32, 1'b0, 32'h0};
    vecs[4]  = '{CMD_IN,      5'd16, 32'hFFFFABCD, 1'b0, 1'b1, 32'h5678ABCD, 6'd32, 32'h0,        6'd32, 1'b0, 32'h0};
    vecs[5]  = '{CMD_SET_ISR, 5'd0,  32'hCAFEF00D, 1'b1, 1'b1, 32'hCAFEF00D, 6'd0,  32'h0,        6'd32, 1'b0, 32'h0};
    vecs[6]  = '{CMD_SET_OSR, 5'd0,  32'h87654321, 1'b1, 1'b1, 32'hCAFEF00D, 6'd0,  32'h87654321, 6'd0,  1'b0, 32'h0};
    vecs[7]  = '{CMD_OUT,     5'd4,  32'h0,        1'b1, 1'b1, 32'hCAFEF00D, 6'd0,  32'h08765432, 6'd4,  1'b1, 32'h1};
    vecs[8]  = '{CMD_OUT,     5'd8,  32'h0,        1'b0, 1'b1, 32'hCAFEF00D, 6'd0,  32'h76543200, 6'd12, 1'b1, 32'h08};
    vecs[9]  = '{CMD_OUT,     5'd0,  32'h0,        1'b1, 1'b1, 32'hCAFEF00D, 6'd0,  32'h0,        6'd32, 1'b1, 32'h76543200};
    vecs[10] = '{CMD_OUT,     5'd4,  32'h0,        1'b0, 1'b1, 32'hCAFEF00D, 6'd0,  32'h0,        6'd32, 1'b1, 32'h0};
    vecs[11] = '{CMD_OUT,     5'd4,  32'h0,        1'b1, 1'b1, 32'hCAFEF00D, 6'd0,  32'h0,        6'd32, 1'b1, 32'h0};
    vecs[12] = '{CMD_RSVD,    5'd8,  32'hFFFFFFFF, 1'b1, 1'b1, 32'hCAFEF00D, 6'd0,  32'h0,        6'd32, 1'b0, 32'h0};
    vecs[13] = '{CMD_IN,      5'd8,  32'h000000FF, 1'b1, 1'b0, 32'hCAFEF00D, 6'd0,  32'h0,        6'd32, 1'b0, 32'h0};

    do_reset();
    check_output("rst_isr", {32'h0, isr}, 64'h0);
    check_output("rst_isr_count", {58'h0, isr_count}, 64'd0);
    check_output("rst_osr", {32'h0, osr}, 64'h0);
    check_output("rst_osr_count", {58'h0, osr_count}, 64'd32);
    check_output("rst_flags", {60'h0, stall, out_valid, rx_valid, tx_ready}, 64'h0);
    check_output("rst_out_bits", {32'h0, out_bits}, 64'h0);

    for (int i = 0; i < 14; i++) begin
      shift_right_in = vecs[i].right;
      shift_right_out = vecs[i].right;
      en = vecs[i].en;
      if (vecs[i].out_exp) out_exp_q.push_back(vecs[i].exp_out);
      apply_stimulus(vecs[i].cmd, vecs[i].n, vecs[i].data, 1'b0, 1'b0);
      en = 1'b1;
      check_output($sformatf("vec%0d_isr", i), {32'h0, isr}, {32'h0, vecs[i].exp_isr});
      check_output($sformatf("vec%0d_isr_count", i), {58'h0, isr_count}, {58'h0, vecs[i].exp_isr_cnt});
      check_output($sformatf("vec%0d_osr", i), {32'h0, osr}, {32'h0, vecs[i].exp_osr});
      check_output($sformatf("vec%0d_osr_count", i), {58'h0, osr_count}, {58'h0, vecs[i].exp_osr_cnt});
      check_output($sformatf("vec%0d_stall", i), {63'h0, stall}, 64'h0);
    end

    // Autopush with the RX side refusing for three cycles.
    do_reset();
    auto_push = 1'b1; push_thresh = 5'd16;
    apply_stimulus(CMD_IN, 5'd8, 32'hAA, 1'b0, 1'b0);
    check_output("ap_first_stall", {63'h0, stall}, 64'h0);
    rx_exp_q.push_back(32'hBBAA0000);
    apply_stimulus(CMD_IN, 5'd8, 32'hBB, 1'b0, 1'b0);
    for (int c = 0; c < 3; c++) begin
      check_output($sformatf("ap_stall_c%0d", c), {62'h0, stall, rx_valid}, 64'h3);
      check_output($sformatf("ap_rx_data_c%0d", c), {32'h0, rx_data}, 64'hBBAA0000);
      if (c < 2) tick();
    end
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
    check_output("ap_done_flags", {62'h0, stall, rx_valid}, 64'h0);
    check_output("ap_done_isr", {26'h0, isr_count, isr}, 64'h0);

    // Autopull from reset: TX delivers two cycles late.
    do_reset();
    auto_pull = 1'b1; pull_thresh = 5'd0;
    apply_stimulus(CMD_OUT, 5'd4, 32'h0, 1'b0, 1'b0);
    check_output("apl_wait", {62'h0, stall, tx_ready}, 64'h3);
    tick();
    check_output("apl_wait2", {61'h0, stall, tx_ready, out_valid}, 64'h6);
    tx_valid = 1'b1; tx_data = 32'h1234567F;
    out_exp_q.push_back(32'hF);
    tick();
    tx_valid = 1'b0;
    check_output("apl_out", {31'h0, out_valid, out_bits}, {31'h0, 1'b1, 32'hF});
    check_output("apl_osr", {32'h0, osr}, 64'h01234567);
    check_output("apl_osr_count", {57'h0, stall, osr_count}, 64'd4);

    // PULL variants: non-blocking empty/full, IfEmpty skip, blocking.
    auto_pull = 1'b0; x_in = 32'hDEADBEEF;
    cmd = CMD_PULL; cmd_block = 1'b0; cmd_cond = 1'b0;
    #1;
    check_output("nbpull_empty_tx_ready", {63'h0, tx_ready}, 64'h0);
    tick();
    cmd = CMD_NOP;
    check_output("nbpull_empty_osr", {26'h0, osr_count, osr}, {26'h0, 6'd0, 32'hDEADBEEF});
    tx_valid = 1'b1; tx_data = 32'h5A5A1234; cmd = CMD_PULL;
    #1;
    check_output("nbpull_full_tx_ready", {63'h0, tx_ready}, 64'h1);
    tick();
    cmd = CMD_NOP; tx_valid = 1'b0;
    check_output("nbpull_full_osr", {25'h0, stall, osr_count, osr}, {26'h0, 6'd0, 32'h5A5A1234});
    apply_stimulus(CMD_PULL, 5'd0, 32'h0, 1'b1, 1'b1);
    check_output("pull_ifempty_skip", {25'h0, stall, osr_count, osr}, {26'h0, 6'd0, 32'h5A5A1234});
    apply_stimulus(CMD_PULL, 5'd0, 32'h0, 1'b1, 1'b0);
    check_output("bpull_wait", {62'h0, stall, tx_ready}, 64'h3);
    tx_valid = 1'b1; tx_data = 32'h0F0F0F0F;
    tick();
    tx_valid = 1'b0;
    check_output("bpull_done", {25'h0, stall, osr_count, osr}, {26'h0, 6'd0, 32'h0F0F0F0F});

    // PUSH variants.
    do_reset();
    push_thresh = 5'd16;
    apply_stimulus(CMD_IN, 5'd8, 32'hA5, 1'b0, 1'b0);
    apply_stimulus(CMD_PUSH, 5'd0, 32'h0, 1'b1, 1'b1);
    check_output("push_iffull_skip", {24'h0, stall, rx_valid, isr_count, isr}, {26'h0, 6'd8, 32'hA5000000});
    apply_stimulus(CMD_PUSH, 5'd0, 32'h0, 1'b0, 1'b0);
    check_output("nbpush_drop", {24'h0, stall, rx_valid, isr_count, isr}, 64'h0);
    apply_stimulus(CMD_SET_ISR, 5'd0, 32'h11223344, 1'b0, 1'b0);
    rx_ready = 1'b1;
    rx_exp_q.push_back(32'h11223344);
    apply_stimulus(CMD_PUSH, 5'd0, 32'h0, 1'b0, 1'b0);
    check_output("nbpush_ready_wait", {62'h0, stall, rx_valid}, 64'h3);
    tick();
    rx_ready = 1'b0;
    check_output("nbpush_ready_done", {24'h0, stall, rx_valid, isr_count, isr}, 64'h0);

    // Reset abandons a pending PUSH; restart abandons a pending PULL.
    apply_stimulus(CMD_SET_ISR, 5'd0, 32'h55, 1'b0, 1'b0);
    apply_stimulus(CMD_PUSH, 5'd0, 32'h0, 1'b1, 1'b0);
    check_output("rst_mid_wait_pre", {62'h0, stall, rx_valid}, 64'h3);
    reset = 1'b1; rx_ready = 1'b1;
    tick();
    reset = 1'b0; rx_ready = 1'b0;
    check_output("rst_mid_wait_flags", {62'h0, stall, rx_valid}, 64'h0);
    check_output("rst_mid_wait_regs", {26'h0, osr_count, isr}, {26'h0, 6'd32, 32'h0});
    apply_stimulus(CMD_SET_OSR, 5'd0, 32'h99, 1'b0, 1'b0);
    apply_stimulus(CMD_PULL, 5'd0, 32'h0, 1'b1, 1'b0);
    restart = 1'b1; tx_valid = 1'b1; tx_data = 32'h77;
    tick();
    restart = 1'b0; tx_valid = 1'b0;
    check_output("restart_mid_pull", {25'h0, stall, osr_count, osr}, {26'h0, 6'd32, 32'h0});

    tick();
    check_output("rx_queue_drained", {32'h0, rx_exp_q.size()}, 64'd0);
    check_output("out_queue_drained", {32'h0, out_exp_q.size()}, 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end
endmodule
